// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serial pattern transmitter. On an accepted start it sends PATTERN (MSB
// first) rep_cnt times, optionally separated by gap_len idle cycles, then
// pulses done for one cycle. abort or reset drop back to IDLE with no done.
module seq_pattern_tx #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [1:0]       gap_len,
  input  logic             abort,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [1:0]       gap_len_q, gap_len_d;
  logic [1:0]       gap_cnt_q, gap_cnt_d;
  logic             d_out_d, d_valid_d;

  // Next-state logic: abort beats everything while a transmission is active.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frames_d  = frames_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SEND;
          idx_d     = IDX_TOP;
          frames_d  = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
          gap_len_d = gap_len;
          gap_cnt_d = 2'd0;
        end
      end

      SEND: begin
        if (abort) begin
          state_d   = IDLE;
          idx_d     = IDX_TOP;
          frames_d  = '0;
          gap_cnt_d = 2'd0;
        end else if (idx_q == '0) begin
          idx_d = IDX_TOP;
          if (frames_q > CNT_W'(1)) begin
            frames_d = frames_q - CNT_W'(1);
            if (gap_len_q != 2'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q;
            end
          end else begin
            frames_d = (frames_q != '0) ? frames_q - CNT_W'(1) : '0;
            state_d  = DONE;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          idx_d     = IDX_TOP;
          frames_d  = '0;
          gap_cnt_d = 2'd0;
        end else if (gap_cnt_q <= 2'd1) begin
          state_d   = SEND;
          idx_d     = IDX_TOP;
          gap_cnt_d = 2'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        idx_d     = IDX_TOP;
        frames_d  = '0;
        gap_cnt_d = 2'd0;
      end
    endcase

    d_valid_d = (state_d == SEND);
    d_out_d   = d_valid_d ? PATTERN[idx_d] : 1'b0;
  end

  // State, counters and the registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= IDX_TOP;
      frames_q  <= '0;
      gap_len_q <= 2'd0;
      gap_cnt_q <= 2'd0;
      d_out     <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frames_q  <= frames_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      d_out     <= d_out_d;
      d_valid   <= d_valid_d;
    end
  end

  assign busy = (state_q == SEND) || (state_q == GAP);
  assign done = (state_q == DONE);

endmodule
